regfile_dump: RTL and testbench

- Debug reader for the processor's 32x32 register bank. On a start pulse it walks register addresses 0..2**AW-1 through one asynchronous read port and streams each word out over a valid/ready interface.
- Sits beside the register bank, sharing one read port via a core-side mux that the top level controls with busy_o. Feeds the board display or a UART debug path.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_dump.sv | 133 +++++++++++++
 tb/tb_regfile_dump.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-bank debug dumper.
package regfile_pkg;
  localparam int REG_DW    = 32;
  localparam int REG_AW    = 5;
  localparam int REG_COUNT = 2 ** REG_AW;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE, CSUM} dump_state_t;
endpackage

// File: rtl/regfile_dump.sv
// Walks the register bank through one async read port and streams each word out.
// Optional trailing XOR checksum word when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] rs_o,
  input  logic [DW-1:0] data_rs_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic [AW-1:0] m_idx_o,
  output logic          m_last_o
);

  localparam logic [AW-1:0] LAST_IDX = '1;

  dump_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] midx_q, midx_d;
  logic          last_q, last_d;
  logic          hs;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0] acc_q, acc_d;
`endif

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign m_valid_o = (state_q == SEND) || (state_q == CSUM);
  assign rs_o      = (state_q == IDLE) ? '0 : idx_q;
  assign m_data_o  = data_q;
  assign m_idx_o   = midx_q;
  assign m_last_o  = last_q;
  assign hs        = m_valid_o & m_ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    midx_d  = midx_q;
    last_d  = last_q;
`ifdef REGDUMP_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          idx_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      LOAD: begin
        // Capture happens on the same edge a bank write lands, so we keep the old value.
        data_d  = data_rs_i;
        midx_d  = idx_q;
`ifdef REGDUMP_CHECKSUM_EN
        last_d  = 1'b0;
`else
        last_d  = (idx_q == LAST_IDX);
`endif
        state_d = SEND;
      end
      SEND: begin
        if (hs) begin
`ifdef REGDUMP_CHECKSUM_EN
          acc_d = acc_q ^ data_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = CSUM;
            data_d  = acc_q ^ data_q;
            midx_d  = '0;
            last_d  = 1'b1;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      CSUM: begin
        if (hs) state_d = DONE;
      end
      DONE: begin
        last_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      midx_q <= '0;
      last_q <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q  <= '0;
`endif
    end else begin
      data_q <= data_d;
      midx_q <= midx_d;
      last_q <= last_d;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q  <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: bank model, directed dumps, then randomized contents/backpressure.
module tb_regfile_dump;
  import regfile_pkg::*;
  localparam int DW = REG_DW;
  localparam int AW = REG_AW;
  localparam int N  = REG_COUNT;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] bank [N];
  logic [DW-1:0] model [N];
  logic [DW-1:0] data_rs;
  logic          busy, done, m_valid, m_last;
  logic [AW-1:0] rs, m_idx;
  logic [DW-1:0] m_data;
  int checks = 0;
  int failures = 0;

  regfile_dump dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .rs_o(rs), .data_rs_i(data_rs), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_idx_o(m_idx), .m_last_o(m_last)
  );

  assign data_rs = bank[rs];
  always @(posedge clk) if (wr_en) bank[wr_addr] <= wr_data;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model[a] = d;
  endtask

  // One full dump; words are checked against a snapshot of the bank model taken at start.
  task automatic dump(input int stall_idx, input int restart_idx, input int wr_idx,
                      input logic [DW-1:0] wr_val);
    logic [DW-1:0] ref_w [N];
    logic [DW-1:0] csum;
    int words, dones, bcyc, stall;
    bit stalled, restarted, wrote, finished;
    csum = '0;
    for (int i = 0; i < N; i++) begin ref_w[i] = model[i]; csum ^= model[i]; end
    words = 0; dones = 0; bcyc = 0; stall = 0;
    stalled = 0; restarted = 0; wrote = 0; finished = 0;
    @(negedge clk);
    start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = 1'b0; wr_en = 1'b0;
      if (!busy) begin finished = 1; break; end
      bcyc++;
      if (done) dones++;
      if (wr_idx >= 0 && !wrote && !m_valid && !done && int'(rs) == wr_idx) begin
        wr_en = 1'b1; wr_addr = AW'(wr_idx); wr_data = wr_val; wrote = 1;
      end
      if (m_valid && stall_idx >= 0 && !stalled && int'(m_idx) == stall_idx && words < N) begin
        stalled = 1; stall = 10;
      end
      if (stall > 0) begin
        chk("stall_valid", DW'(m_valid), DW'(1));
        chk("stall_data", m_data, ref_w[stall_idx]);
        chk("stall_idx", DW'(m_idx), DW'(stall_idx));
        stall--;
        m_ready = 1'b0;
      end else m_ready = 1'b1;
      if (m_valid && m_ready) begin
        if (words < N) begin
          chk("word_data", m_data, ref_w[words]);
          chk("word_idx", DW'(m_idx), DW'(words));
          chk("word_last", DW'(m_last), DW'((CS == 0) && (words == N - 1)));
        end else begin
          chk("csum_data", m_data, csum);
          chk("csum_idx", DW'(m_idx), DW'(0));
          chk("csum_last", DW'(m_last), DW'(1));
        end
        words++;
      end
      if (restart_idx >= 0 && !restarted && m_valid && int'(m_idx) == restart_idx) begin
        start = 1'b1; restarted = 1;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0;
    chk("dump_finished", DW'(finished), DW'(1));
    chk("word_count", DW'(words), DW'(N + CS));
    chk("done_count", DW'(dones), DW'(1));
    chk("busy_cycles", DW'(bcyc), DW'(2 * N + 1 + CS + (stalled ? 10 : 0)));
    if (wrote) model[wr_idx] = wr_val;
    repeat (3) @(negedge clk);
    chk("idle_after", DW'(busy), DW'(0));
    chk("idle_valid", DW'(m_valid), DW'(0));
  endtask

  initial begin
    bit found;
    #2;
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_rs", DW'(rs), DW'(0));
    chk("rst_valid", DW'(m_valid), DW'(0));
    chk("rst_data", m_data, DW'(0));
    chk("rst_idx", DW'(m_idx), DW'(0));
    chk("rst_last", DW'(m_last), DW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) wr(AW'(i), 32'hA500_0000 + DW'(i));
    chk("idle_rs", DW'(rs), DW'(0));

    dump(-1, -1, -1, '0);                 // plain full dump
    dump(3, -1, -1, '0);                  // backpressure at idx 3
    dump(-1, -1, 7, 32'hDEAD_BEEF);       // write lands on LOAD edge of idx 7
    dump(-1, 10, -1, '0);                 // stray start mid-dump, sees DEADBEEF
    chk("reg7_second", model[7], 32'hDEAD_BEEF);

    // Reset while presenting idx 15.
    @(negedge clk); start = 1'b1; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (m_valid && m_idx == AW'(15)) begin found = 1; break; end
      @(negedge clk);
    end
    chk("reach_idx15", DW'(found), DW'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", DW'(m_valid), DW'(0));
    chk("mid_rst_busy", DW'(busy), DW'(0));
    chk("mid_rst_done", DW'(done), DW'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", DW'(done), DW'(0));
      chk("post_rst_busy", DW'(busy), DW'(0));
    end
    dump(-1, -1, -1, '0);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) wr(AW'(i), DW'($urandom));
      dump(int'($urandom_range(0, N - 1)), -1, -1, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
